// File: rtl/im_prefetch_if.sv
// Fetch-side bundle of the instruction prefetcher: SRAM read port plus CPU instruction stream.
// Latency: none, wires only.
// Backpressure: instr_ready from the CPU; the SRAM side has no stall.
// Ports: master = prefetch unit (drives IM_CEB/IM_A and the instr_* stream),
//        slave  = environment (SRAM data, CPU redirect and ready).
interface im_prefetch_if;
    logic        IM_CEB;
    logic [13:0] IM_A;
    logic [31:0] IM_DO;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output IM_CEB, IM_A, instr_valid, instr, instr_pc,
        input  IM_DO, redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  IM_CEB, IM_A, instr_valid, instr, instr_pc,
        output IM_DO, redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/im_prefetch.sv
// Sequential instruction prefetcher feeding a DEPTH-entry FIFO from a 1-cycle-latency SRAM.
// Latency: issue in N, data captured in N+1, instr_valid in N+2; redirect R -> first valid R+3.
// Backpressure: issues are credited against count+inflight, so the FIFO never overflows.
// Ports: clk, rst (sync, active-high); bus (im_prefetch_if.master): IM_CEB/IM_A/IM_DO to the
//        SRAM, redirect/redirect_pc from the CPU, instr_valid/instr/instr_pc/instr_ready stream.
module im_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    im_prefetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [31:0]      fetch_pc_q,    fetch_pc_d;
    logic             inflight_q,    inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic             stale_q,       stale_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [CNT_W-1:0] count_q,       count_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    logic [CNT_W:0]   occ;
    logic             issue;
    logic             head_vld;
    logic             push;
    logic             pop;
    logic             unused_rpc_lsb;

    // Only the word address of a redirect target matters.
    assign unused_rpc_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        // Occupancy includes the read on the SRAM bus; a same-cycle pop earns no credit.
        occ      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue    = !rst && !bus.redirect && (occ < DEPTH_OCC);
        head_vld = !rst && (count_q != '0);
        pop      = head_vld && bus.instr_ready && !bus.redirect;
        // Data returning in a redirect cycle belongs to the old path and is dropped here.
        push     = inflight_q && !stale_q && !bus.redirect && !rst;

        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        // With a 1-cycle SRAM the drop always happens inside the redirect cycle,
        // so nothing ever needs to be marked stale.
        stale_d       = 1'b0;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        mem_d         = mem_q;

        if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{pc: inflight_pc_q, instr: bus.IM_DO};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

        if (bus.redirect) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        // Storage needs no reset: an empty FIFO masks every entry.
        mem_q <= mem_d;
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            stale_q       <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            stale_q       <= stale_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    assign bus.IM_CEB      = !issue;
    assign bus.IM_A        = rst ? RESET_PC[15:2] : fetch_pc_q[15:2];
    assign bus.instr_valid = head_vld;
    assign bus.instr       = head_vld ? mem_q[rd_ptr_q].instr : '0;
    assign bus.instr_pc    = head_vld ? mem_q[rd_ptr_q].pc    : '0;
endmodule

// File: tb/tb_im_prefetch.sv
// Bench for im_prefetch: directed scenarios plus a random run against a queue-based model.
// Latency: n/a.
// Backpressure: instr_ready driven directly and randomly.
module tb_im_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    im_prefetch_if bif ();

    im_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int checks = 0;
    int errors = 0;
    int issues = 0;

    // SRAM model: word i holds 32'h1000_0000 + i.
    logic        sram_vld = 1'b0;
    logic [13:0] sram_a   = '0;

    // Reference model: buffered pcs, read in flight, next fetch address.
    logic [31:0] mq [$];
    logic        m_infl   = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic [31:0] m_fpc    = RESET_PC;
    logic [31:0] s_next   = RESET_PC;

    // Last observed DUT outputs.
    logic        o_vld, o_ceb;
    logic [31:0] o_pc, o_instr;
    logic [13:0] o_a;

    function automatic logic [31:0] word(input logic [31:0] pc);
        logic [13:0] a;
        a = pc[15:2];
        return 32'h1000_0000 + {18'b0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle; entered and left #1 after a rising edge.
    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic        e_vld, e_issue;
        logic [31:0] e_pc, e_instr, rst_pc;
        logic [13:0] e_a;
        bif.IM_DO          = sram_vld ? 32'h1000_0000 + {18'b0, sram_a} : 32'hDEAD_BEEF;
        rst                = r;
        bif.redirect       = rd;
        bif.redirect_pc    = rpc;
        bif.instr_ready    = rdy;
        #1;
        rst_pc  = RESET_PC;
        e_vld   = !r && (mq.size() > 0);
        e_pc    = e_vld ? mq[0] : 32'h0;
        e_instr = e_vld ? word(e_pc) : 32'h0;
        e_issue = !r && !rd && ((mq.size() + (m_infl ? 1 : 0)) < DEPTH);
        e_a     = r ? rst_pc[15:2] : m_fpc[15:2];

        o_vld   = bif.instr_valid;
        o_pc    = bif.instr_pc;
        o_instr = bif.instr;
        o_ceb   = bif.IM_CEB;
        o_a     = bif.IM_A;

        chk("instr_valid", {31'b0, o_vld}, {31'b0, e_vld});
        chk("instr_pc", o_pc, e_pc);
        chk("instr", o_instr, e_instr);
        chk("IM_CEB", {31'b0, o_ceb}, {31'b0, !e_issue});
        chk("IM_A", {18'b0, o_a}, {18'b0, e_a});
        // Consumed instructions must be contiguous from the last restart point.
        if (o_vld && rdy && !rd && !r) begin
            chk("stream_order", o_pc, s_next);
            s_next = s_next + 32'd4;
        end

        sram_vld = !o_ceb;
        sram_a   = o_a;
        if (!o_ceb) issues++;

        if (r) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = RESET_PC;
            s_next = RESET_PC;
        end else if (rd) begin
            mq.delete();
            m_infl = 1'b0;
            m_fpc  = {rpc[31:2], 2'b00};
            s_next = m_fpc;
        end else begin
            if (e_vld && rdy) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            m_infl    = e_issue;
            m_infl_pc = m_fpc;
            if (e_issue) m_fpc = m_fpc + 32'd4;
        end

        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bif.IM_DO       = '0;
        bif.redirect    = 1'b0;
        bif.redirect_pc = '0;
        bif.instr_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset stream: first issue in cycle 0, first instruction in cycle 2.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_first_issue", {31'b0, o_ceb}, 32'd0);
        step(0, 0, 0, 1);
        chk("rst_c1_valid", {31'b0, o_vld}, 32'd0);
        step(0, 0, 0, 1);
        chk("rst_c2_valid", {31'b0, o_vld}, 32'd1);
        chk("rst_c2_pc", o_pc, RESET_PC);
        chk("rst_c2_instr", o_instr, 32'h1000_0000);
        for (int i = 0; i < 17; i++) step(0, 0, 0, 1);

        // Backpressure from reset: exactly DEPTH reads, head stays at pc 0.
        step(1, 0, 0, 0);
        issues = 0;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("bp_issue_count", issues, DEPTH);
        chk("bp_head_pc", o_pc, RESET_PC);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1);

        // Redirect flush with 3 buffered and one read in flight.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0102, 0);
        step(0, 0, 0, 1);
        chk("flush_r1_valid", {31'b0, o_vld}, 32'd0);
        chk("flush_r1_issue", {31'b0, o_ceb}, 32'd0);
        step(0, 0, 0, 1);
        chk("flush_r2_valid", {31'b0, o_vld}, 32'd0);
        step(0, 0, 0, 1);
        chk("flush_r3_valid", {31'b0, o_vld}, 32'd1);
        chk("flush_r3_pc", o_pc, 32'h0000_0100);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

        // Redirect while the head is being accepted: the head is not consumed.
        chk("rp_head_valid", {31'b0, bif.instr_valid}, 32'd1);
        step(0, 1, 32'h2000_0040, 1);
        step(0, 0, 0, 1);
        chk("rp_r1_empty", {31'b0, o_vld}, 32'd0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rp_r3_pc", o_pc, 32'h2000_0040);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // 64 KiB wrap of the SRAM word address.
        step(0, 1, 32'h0000_FFF8, 1);
        step(0, 0, 0, 1);
        chk("wrap_a0", {18'b0, o_a}, 32'h3FFE);
        step(0, 0, 0, 1);
        chk("wrap_a1", {18'b0, o_a}, 32'h3FFF);
        step(0, 0, 0, 1);
        chk("wrap_a2", {18'b0, o_a}, 32'h0000);
        chk("wrap_pc0", o_pc, 32'h0000_FFF8);
        step(0, 0, 0, 1);
        chk("wrap_a3", {18'b0, o_a}, 32'h0001);
        chk("wrap_pc1", o_pc, 32'h0000_FFFC);
        step(0, 0, 0, 1);
        chk("wrap_pc2", o_pc, 32'h0001_0000);
        chk("wrap_instr2", o_instr, 32'h1000_0000);
        step(0, 0, 0, 1);
        chk("wrap_pc3", o_pc, 32'h0001_0004);

        // Mid-run reset with the FIFO full.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("mrst_valid", {31'b0, o_vld}, 32'd0);
        chk("mrst_ceb", {31'b0, o_ceb}, 32'd1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("mrst_c2_pc", o_pc, RESET_PC);
        chk("mrst_c2_valid", {31'b0, o_vld}, 32'd1);

        // Random traffic: ready, redirects and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic r, rd, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 1);
            rd  = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 65);
            rpc = $urandom;
            step(r, rd, rpc, rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/im_prefetch.md
# im_prefetch

Instruction prefetch unit between the CPU fetch stage and the instruction-memory `SRAM_wrapper`. It generates sequential word addresses, drives the SRAM read port and absorbs the SRAM's one-cycle read latency. Fetched words go into a small FIFO, which presents a valid/ready instruction stream to the CPU. A CPU redirect (branch, jump or trap) flushes the FIFO and discards any read still in flight.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `IM_CEB`, output, 1: SRAM chip enable, active low; low only in an issue cycle.
- `IM_A`, output, 14: SRAM word address, equal to `fetch_pc[15:2]`.
- `IM_DO`, input, 32: SRAM read data, valid the cycle after an issue.
- `redirect`, input, 1: CPU requests a fetch restart.
- `redirect_pc`, input, 32: restart byte address; bits [1:0] are ignored and treated as 0.
- `instr_valid`, output, 1: the FIFO head holds an instruction.
- `instr`, output, 32: FIFO head instruction; 0 when `instr_valid`=0.
- `instr_pc`, output, 32: byte address of `instr`; 0 when `instr_valid`=0.
- `instr_ready`, input, 1: CPU accepts the head this cycle.

## Operation
State:
- `fetch_pc` (32b): next address to issue.
- `inflight` (1b): a read was issued last cycle.
- `inflight_pc` (32b): address of that read.
- `stale` (1b): the in-flight read must be dropped.
- FIFO: `DEPTH` entries of {pc, instr}, with read and write pointers and `count` (width clog2(DEPTH)+1).

Behaviour:
- **Issue condition:** `!rst && !redirect && (count + inflight) < DEPTH`. The same-cycle pop is not credited. On issue, `IM_CEB`=0 and `fetch_pc` <= `fetch_pc`+4, modulo 2^32.
- **Capture:** in the cycle with `inflight`=1 and `stale`=0, push {`inflight_pc`, `IM_DO`}. The credit rule guarantees room, so a push never sees a full FIFO.
- **Pop:** occurs when `instr_valid && instr_ready && !redirect`. Push and pop in the same cycle leave `count` unchanged.
- **Redirect cycle:**
  - `fetch_pc` <= {`redirect_pc[31:2]`, 2'b00}.
  - The FIFO is emptied and `count` <= 0.
  - No issue this cycle.
  - If `inflight`=1, its data is not pushed.
  - Redirect takes priority over pop and push in the same cycle.
- **`stale`:** set by a redirect while `inflight`=1 is only needed if the capture would otherwise land after the flush. With the rules above the drop happens inside the redirect cycle, so `stale` is cleared every cycle. It is kept for a 2-cycle SRAM option and must be 0 in this configuration.
- **Address wrap:** `IM_A` wraps from 14'h3FFF to 14'h0000 when `fetch_pc` crosses a 64 KiB boundary. `instr_pc` carries the full 32 bits.
- **Reset:** values take effect on the clock edge where `rst`=1, and `rst` mid-operation discards everything.
  - `fetch_pc`=`RESET_PC`.
  - FIFO empty; `inflight`=0; `stale`=0.
  - Outputs during reset: `IM_CEB`=1, `IM_A`=`RESET_PC[15:2]`, `instr_valid`=0, `instr`=0, `instr_pc`=0.

## Timing
- **`IM_CEB` and `IM_A`:** combinational from registered state and `redirect`. `instr`, `instr_pc` and `instr_valid` come from registered FIFO storage with no `IM_DO` bypass.
- **Fetch latency:** issue in cycle N, `IM_DO` valid and pushed in N+1, `instr_valid`=1 in N+2.
- **After reset:** with `rst` low first in cycle 0, the first issue is in cycle 0 and the first `instr_valid` is in cycle 2 with `instr_pc`=`RESET_PC`.
- **After redirect:** a redirect in cycle R gives an issue in R+1 and `instr_valid` in R+3 carrying `redirect_pc`. `instr_valid`=0 in R+1 and R+2.
- **Throughput:** with `instr_ready` held at 1, one instruction per cycle after start-up.
- **Backpressure:** with `instr_ready`=0, issues stop once `count+inflight`=`DEPTH`. No word is lost or duplicated, and `instr`/`instr_pc` stay stable while `instr_valid`=1 and not popped.

## Test plan
- **Reset stream:** `RESET_PC`=0, IM preloaded with word i = 32'h1000_0000+i, `instr_ready`=1 → `instr_valid` from cycle 2 with `instr` 10000000, 10000001, … and `instr_pc` 0, 4, 8, … on consecutive cycles.
- **Backpressure:** hold `instr_ready`=0 for 10 cycles → exactly 4 reads issued (`IM_CEB` low 4 times), `count`=4, head remains pc 0. On release, 4 words drain, then the stream resumes at pc 16 with no gap or repeat.
- **Redirect flush:** redirect to 32'h0000_0102 while 3 entries are buffered and one read is in flight → the next valid output is at R+3 with `instr_pc`=32'h100, and no old-address word ever appears.
- **Redirect with pop:** `redirect`=1 and `instr_ready`=1 with `instr_valid`=1 → the head is not counted as consumed, the FIFO is empty in R+1, and the first output is the redirect target.
- **Wrap:** redirect to 32'h0000_FFF8 → `IM_A` sequence 3FFE, 3FFF, 0000, 0001, with `instr_pc` FFF8, FFFC, 10000, 10004.
- **Mid-run reset:** assert `rst` for 1 cycle with the FIFO full → `instr_valid`=0 and `IM_CEB`=1 during reset, then the stream restarts at `RESET_PC` with correct latency.
